// File: rtl/uart_tx_io.sv
// uart_tx_io: memory-mapped 8N1 UART transmitter for the MIO bus.
//
// CPU stores land in a small circular FIFO. A four-state framer drains the
// FIFO and shifts each byte out LSB first on txd. A registered status word
// is returned to the bus read mux so software can poll it.
//
// Ports:
//   clk     system clock (100 MHz board domain)
//   RSTN    asynchronous active-low reset
//   we      write strobe for this device, one cycle per store
//   din     write data: din[8]=0 pushes din[7:0], din[8]=1 clears overflow
//   status  {20'b0, overflow, busy, full, empty, .., count} (registered)
//   txd     serial output, idle high (registered)
//
// DEPTH_LOG2 must be in 1..7 so the count field stays below bit 8.
module uart_tx_io #(
  parameter int BAUD_DIV   = 868,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] status,
  output logic        txd
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BW    = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]         BAUD_MAX = BW'(BAUD_DIV - 1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   count, count_n;
  logic                  ovf, ovf_n;
  logic [1:0]            state, state_n;
  logic [BW-1:0]         baud, baud_n;
  logic [2:0]            bidx, bidx_n;
  logic [7:0]            shreg, shreg_n;
  logic                  txd_n;
  logic [31:0]           status_n;

  logic baud_zero, fifo_ne, pop, push_req, push, drop, ctl;
  logic din_unused;

  assign din_unused = ^din[31:9];

  assign baud_zero = (baud == '0);
  assign fifo_ne   = (count != '0);
  // Pops happen only when a new frame is launched: from IDLE, or at the end
  // of a stop bit so consecutive frames abut with no idle cycle.
  assign pop       = fifo_ne && ((state == S_IDLE) || (state == S_STOP && baud_zero));
  assign push_req  = we & ~din[8];
  // A same-cycle pop frees a slot, so a full FIFO still accepts the byte.
  assign push      = push_req && ((count != CNT_FULL) || pop);
  assign drop      = push_req && !push;
  assign ctl       = we & din[8];

  // Framer next-state. txd is computed from the next state so the output
  // register changes on the same edge as the state register.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bidx_n  = bidx;
    shreg_n = shreg;
    txd_n   = txd;
    case (state)
      S_IDLE: begin
        txd_n = 1'b1;
        if (fifo_ne) begin
          shreg_n = mem[rptr];
          baud_n  = BAUD_MAX;
          state_n = S_START;
          txd_n   = 1'b0;
        end
      end
      S_START: begin
        if (baud_zero) begin
          baud_n  = BAUD_MAX;
          bidx_n  = 3'd0;
          state_n = S_DATA;
          txd_n   = shreg[0];
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      S_DATA: begin
        if (baud_zero) begin
          baud_n  = BAUD_MAX;
          shreg_n = {1'b0, shreg[7:1]};
          if (bidx == 3'd7) begin
            state_n = S_STOP;
            txd_n   = 1'b1;
          end else begin
            bidx_n = bidx + 3'd1;
            txd_n  = shreg[1];
          end
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      S_STOP: begin
        if (baud_zero) begin
          if (fifo_ne) begin
            shreg_n = mem[rptr];
            baud_n  = BAUD_MAX;
            state_n = S_START;
            txd_n   = 1'b0;
          end else begin
            // Park the counter at zero; it does not run while idle.
            baud_n  = '0;
            state_n = S_IDLE;
            txd_n   = 1'b1;
          end
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        baud_n  = '0;
        txd_n   = 1'b1;
      end
    endcase
  end

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
    // A new overflow wins over a clear in the same cycle.
    ovf_n = drop ? 1'b1 : (ctl ? 1'b0 : ovf);
  end

  // Status is built from next-state values so a load in the cycle after a
  // store already sees that store's effect.
  always_comb begin
    status_n                 = '0;
    status_n[DEPTH_LOG2:0]   = count_n;
    status_n[8]              = (count_n == '0);
    status_n[9]              = (count_n == CNT_FULL);
    status_n[10]             = (state_n != S_IDLE);
    status_n[11]             = ovf_n;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din[7:0];
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state  <= S_IDLE;
      baud   <= '0;
      bidx   <= '0;
      shreg  <= '0;
      txd    <= 1'b1;
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      status <= 32'h0000_0100;
    end else begin
      state  <= state_n;
      baud   <= baud_n;
      bidx   <= bidx_n;
      shreg  <= shreg_n;
      txd    <= txd_n;
      count  <= count_n;
      ovf    <= ovf_n;
      status <= status_n;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_io.sv
// Testbench for uart_tx_io with BAUD_DIV=4, DEPTH=4. Every accepted byte is
// queued when written; a serial monitor decodes txd frames, checks bit
// widths and the stop bit, and pops the queue to compare the data byte.
module tb_uart_tx_io;

  localparam int BD = 4;

  logic        clk;
  logic        RSTN;
  logic        we;
  logic [31:0] din;
  logic [31:0] status;
  logic        txd;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] sb[$];

  int         mon_cyc;
  logic [9:0] mon_bits;
  bit         mon_act;

  uart_tx_io #(.BAUD_DIV(BD), .DEPTH_LOG2(2)) dut (
    .clk    (clk),
    .RSTN   (RSTN),
    .we     (we),
    .din    (din),
    .status (status),
    .txd    (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Caller is positioned just after a rising edge; returns 1ns after the next.
  task automatic wr(input logic [31:0] d, input bit acc);
    we  = 1'b1;
    din = d;
    if (acc) sb.push_back(d[7:0]);
    @(posedge clk);
    #1;
    we  = 1'b0;
    din = '0;
  endtask

  task automatic busy_window(input int n, output int ones, output int rises);
    logic prev;
    prev  = 1'b0;
    ones  = 0;
    rises = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (status[10] === 1'b1) ones++;
      if (status[10] === 1'b1 && prev == 1'b0) rises++;
      prev = status[10];
    end
  endtask

  // Serial frame monitor.
  initial begin
    mon_act = 1'b0;
    forever begin
      @(negedge clk);
      if (RSTN !== 1'b1) begin
        mon_act = 1'b0;
      end else if (!mon_act) begin
        if (txd === 1'b0) begin
          mon_act  = 1'b1;
          mon_cyc  = 0;
          mon_bits = '0;
        end
      end else begin
        mon_cyc++;
        if (mon_cyc % BD == 0) mon_bits[mon_cyc/BD] = txd;
        else chk("bit_hold", 32'(txd), 32'(mon_bits[mon_cyc/BD]));
        if (mon_cyc == 10*BD-1) begin
          mon_act = 1'b0;
          chk("stop_bit", 32'(mon_bits[9]), 1);
          chk("frame_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) chk("frame_data", 32'(mon_bits[8:1]), 32'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    int ones, rises, lows;
    we   = 1'b0;
    din  = '0;
    RSTN = 1'b1;
    #1 RSTN = 1'b0;
    #2;
    chk("reset_status", status, 32'h100);
    chk("reset_txd", 32'(txd), 1);
    repeat (3) @(posedge clk);
    #1 RSTN = 1'b1;
    @(posedge clk); #1;

    // Single frame 0x55.
    wr(32'h55, 1'b1);
    @(negedge clk);
    chk("t1_txd_before_start", 32'(txd), 1);
    chk("t1_status_count1", status, 32'h001);
    @(negedge clk);
    chk("t1_txd_start", 32'(txd), 0);
    chk("t1_busy_first", 32'(status[10]), 1);
    busy_window(59, ones, rises);
    chk("t1_busy_len", 32'(ones + 1), 40);
    chk("t1_idle_status", status, 32'h100);

    // Back-to-back frames with no idle gap.
    @(posedge clk); #1;
    wr(32'hA3, 1'b1);
    wr(32'h0F, 1'b1);
    busy_window(100, ones, rises);
    chk("t2_busy_len", 32'(ones), 80);
    chk("t2_contiguous", 32'(rises), 1);
    chk("t2_idle_status", status, 32'h100);

    // Status poll with two bytes queued behind an active frame.
    @(posedge clk); #1;
    wr(32'h81, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    wr(32'h42, 1'b1);
    wr(32'h24, 1'b1);
    @(negedge clk);
    chk("poll_count2_busy", status, 32'h402);
    repeat (130) @(negedge clk);
    chk("poll_idle", status, 32'h100);

    // Overflow: six writes into a 4-deep FIFO, last one dropped.
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) wr(32'h10 + 32'(i), i < 5);
    @(negedge clk);
    chk("ovf_set_full", status, 32'hE04);
    wr(32'h100, 1'b0);
    @(negedge clk);
    chk("ovf_cleared", status, 32'h604);
    repeat (220) @(negedge clk);
    chk("ovf_drained", status, 32'h100);
    chk("ovf_all_sent", 32'(sb.size()), 0);

    // Reset in the middle of bit 3 of a queued burst.
    @(posedge clk); #1;
    wr(32'hF0, 1'b1);
    wr(32'h33, 1'b1);
    wr(32'h66, 1'b1);
    repeat (17) @(posedge clk);
    #2;
    chk("rst_mid_bit3_low", 32'(txd), 0);
    RSTN = 1'b0;
    sb.delete();
    #1;
    chk("rst_txd_async", 32'(txd), 1);
    chk("rst_status_async", status, 32'h100);
    repeat (2) @(posedge clk);
    #1 RSTN = 1'b1;
    @(negedge clk);
    chk("rst_status_release", status, 32'h100);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    chk("rst_no_frames", 32'(lows), 0);
    chk("rst_status_final", status, 32'h100);
    chk("sb_empty_end", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
